// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, FSM encoding and lane/plane helpers for the
// iterative theta-inverse block.
package keccak_pkg;
    localparam int LANE_W           = 64;
    localparam int PLANE_W          = 320;
    localparam int STATE_W          = 1600;
    localparam int INV_THETA_PERIOD = 960;
    localparam int INV_THETA_ITERS  = 959;

    typedef enum logic [2:0] {IDLE, LOAD, ITER, APPLY, DONE} inv_state_e;

    // Bit offset of lane (x,y) inside the 1600-bit state.
    function automatic int lane_off(input int x, input int y);
        return LANE_W * (5 * x + y);
    endfunction

    // 64-bit rotate left by one (bit 63 wraps to bit 0).
    function automatic logic [LANE_W-1:0] rol1(input logic [LANE_W-1:0] v);
        return {v[LANE_W-2:0], v[LANE_W-1]};
    endfunction

    // Column parity plane: C[x] = XOR over y of lane (x,y).
    function automatic logic [PLANE_W-1:0] col_parity(input logic [STATE_W-1:0] s);
        logic [PLANE_W-1:0] p;
        p = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                p[x*LANE_W +: LANE_W] ^= s[lane_off(x, y) +: LANE_W];
        return p;
    endfunction

    // Theta mixing plane: D[x] = C[x-1] ^ ROL1(C[x+1]).
    function automatic logic [PLANE_W-1:0] theta_d(input logic [PLANE_W-1:0] c);
        logic [PLANE_W-1:0] d;
        for (int x = 0; x < 5; x++)
            d[x*LANE_W +: LANE_W] = c[((x + 4) % 5)*LANE_W +: LANE_W]
                                  ^ rol1(c[((x + 1) % 5)*LANE_W +: LANE_W]);
        return d;
    endfunction

    // XOR D[x] into every lane of column x.
    function automatic logic [STATE_W-1:0] xor_d(input logic [STATE_W-1:0] s,
                                                 input logic [PLANE_W-1:0] d);
        logic [STATE_W-1:0] r;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                r[lane_off(x, y) +: LANE_W] = s[lane_off(x, y) +: LANE_W] ^ d[x*LANE_W +: LANE_W];
        return r;
    endfunction
endpackage

// File: rtl/theta_plane_step.sv
// theta_plane_step: one application of T on the 320-bit column-parity plane,
// T(P)[x] = P[x] ^ P[x-1] ^ ROL1(P[x+1]). Purely combinational.
module theta_plane_step
    import keccak_pkg::*;
(
    input  logic [PLANE_W-1:0] p_in,
    output logic [PLANE_W-1:0] p_out
);
    for (genvar x = 0; x < 5; x++) begin : g_col
        assign p_out[x*LANE_W +: LANE_W] = p_in[x*LANE_W +: LANE_W]
                                         ^ p_in[((x + 4) % 5)*LANE_W +: LANE_W]
                                         ^ rol1(p_in[((x + 1) % 5)*LANE_W +: LANE_W]);
    end
endmodule

// File: rtl/keccak_theta_inv.sv
// keccak_theta_inv: iterative inverse of Keccak theta. The parity plane of the
// input is pushed through T^959 (= T^-1) in UNROLL-wide steps, then the
// recovered D is XORed back into the stored state.
// Optional macro KECCAK_THETA_INV_CHECK_EN adds chk_err, a forward-theta
// self-check of the result while it is presented.
module keccak_theta_inv
    import keccak_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
`ifdef KECCAK_THETA_INV_CHECK_EN
    ,
    output logic               chk_err
`endif
);
    localparam int ITERS = INV_THETA_ITERS / UNROLL;
    localparam int CNT_W = 10;

    logic [1:0]                rst_sync;
    logic                      rst_i_n;
    inv_state_e                st_q, st_d;
    logic [STATE_W-1:0]        stored_q, out_q;
    logic [PLANE_W-1:0]        plane_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      last_iter;
    logic [UNROLL:0][PLANE_W-1:0] chain;

    // asserts immediately with rst_n, releases two edges later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    assign chain[0] = plane_q;
    for (genvar u = 0; u < UNROLL; u++) begin : g_step
        theta_plane_step u_step (.p_in(chain[u]), .p_out(chain[u+1]));
    end

    assign last_iter = (cnt_q == CNT_W'(ITERS - 1));
    assign in_ready  = (st_q == IDLE);
    assign busy      = (st_q != IDLE);
    assign out_valid = (st_q == DONE);
    assign state_out = out_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) st_q <= IDLE;
        else          st_q <= st_d;
    end

    // next-state: capture, load plane, iterate, apply, hold until taken
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    if (in_valid)  st_d = LOAD;
            LOAD:                   st_d = ITER;
            ITER:    if (last_iter) st_d = APPLY;
            APPLY:                  st_d = DONE;
            DONE:    if (out_ready) st_d = IDLE;
            default:                st_d = IDLE;
        endcase
    end

    // datapath registers, each written only in its own FSM state
    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            stored_q <= '0;
            plane_q  <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else begin
            case (st_q)
                IDLE:  if (in_valid) stored_q <= state_in;
                LOAD:  begin
                    plane_q <= col_parity(stored_q);
                    cnt_q   <= '0;
                end
                ITER:  begin
                    plane_q <= chain[UNROLL];
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                APPLY: out_q <= xor_d(stored_q, theta_d(plane_q));
                default: ;
            endcase
        end
    end

`ifdef KECCAK_THETA_INV_CHECK_EN
    logic [STATE_W-1:0] fwd;
    // re-apply forward theta to the result; it must reproduce the input
    always_comb begin
        fwd = xor_d(out_q, theta_d(col_parity(out_q)));
    end
    assign chk_err = (st_q == DONE) && (fwd != stored_q);
`endif
endmodule

// File: doc/keccak_theta_inv.md
Name: keccak_theta_inv

Overview:
- Iterative inverse of the Keccak theta step: takes a 1600-bit state b = theta(a) and returns a.
- Sits beside the combinational forward theta; used by the decryption/analysis path and by the self-check bench.
- Method: column-parity plane P = C(b) satisfies P = T(C(a)), where T(P)[x] = P[x] ^ P[x-1] ^ ROL1(P[x+1]) (x mod 5).
- T^960 = I, so C(a) = T^959(P). Then D[x] = C[x-1] ^ ROL1(C[x+1]) and a = b ^ D.

Parameters:
- UNROLL, 1, T applications per ITER cycle; legal values 1 or 7 (both divide 959); ITERS = 959/UNROLL.
- LANE_W, 64, lane width; fixed, from the package.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  state_in is valid.
- in_ready  output  1  block can accept a state (high only in IDLE).
- state_in  input  1600  b; lane (x,y) at bits [64*(5x+y) +: 64], x = column (C[x] = XOR over y).
- out_valid  output  1  state_out is valid.
- out_ready  input  1  consumer accepts state_out.
- state_out  output  1600  recovered a; same lane layout as state_in.
- busy  output  1  high in LOAD, ITER, APPLY or DONE.

Behaviour:
- Reset (async assert, sync deassert via flops): state = IDLE, in_ready=1, out_valid=0, busy=0, state_out=0, counter=0, plane register=0.
- IDLE: in_valid&&in_ready captures state_in into state register -> LOAD.
- LOAD (1 cycle): plane register <= column parity of stored state; counter <= 0 -> ITER.
- ITER: each cycle plane <= T^UNROLL(plane); counter++. After the cycle where counter == ITERS-1 -> APPLY. Counter width is ceil(log2(959)) = 10 bits; no wrap occurs.
- APPLY (1 cycle): compute D from plane; state_out <= stored ^ D (every lane in column x XORed with D[x]) -> DONE.
- DONE: out_valid=1 and state_out held stable until out_ready. On handshake -> IDLE.
- Latency: out_valid rises exactly ITERS+2 cycles after the input handshake cycle (961 for UNROLL=1, 139 for UNROLL=7).
- in_ready is 0 outside IDLE; input is never accepted in the DONE-handshake cycle. Minimum gap between accepts is ITERS+3 cycles.
- in_valid while busy: ignored, no capture.
- out_ready held low: block stalls in DONE indefinitely with no state change.
- Reset mid-operation: result is abandoned; all outputs return to reset values immediately.
- ROL1 is a 64-bit rotate left by 1 (bit 63 -> bit 0). All index arithmetic on x is mod 5.

Optional Feature:
- Macro KECCAK_THETA_INV_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit).
  - In DONE, forward theta is applied combinationally to state_out and compared with the stored input.
  - chk_err = 1 on mismatch, valid while out_valid; chk_err = 0 in all other states and at reset.
- Undefined: no port, no logic.

Decomposition:
- keccak_pkg holds: LANE_W=64, PLANE_W=320, STATE_W=1600, INV_THETA_PERIOD=960, INV_THETA_ITERS=959, the lane offset function (64*(5x+y)), the state enum {IDLE, LOAD, ITER, APPLY, DONE}, and a ROL1 function.
- One sub-module, theta_plane_step: purely combinational T on the 320-bit plane. Instantiated UNROLL times in a chain.

Test Plan:
- Reset, then state_in = all zeros -> state_out = 0 after 961 cycles (UNROLL=1); in_ready = 0 throughout.
- state_in with lane00 = 0x1, lanes10..14 = 0x1, lanes40..44 = 0x2, others 0 (this is theta of a single bit) -> state_out lane00 = 0x1, all other lanes 0.
- 1000 random a: drive forward theta(a) -> state_out == a for UNROLL=1 and UNROLL=7; latencies 961 and 139.
- out_ready held low for 50 cycles in DONE -> state_out stable and out_valid held; in_valid pulses in that window are ignored.
- rst_n asserted at ITER counter = 500 -> out_valid=0, in_ready=1 immediately. A new input then completes correctly with full latency.
- CHECK_EN defined, normal input -> chk_err = 0. Force one bit of the plane register during ITER -> chk_err = 1 in DONE.
